platform_utils_ccip_tx_af_buf: RTL

PLATFORM_UTILS_CCIP_TX_AF_BUF -- requirements
Module: platform_utils_ccip_tx_af_buf

---
 rtl/platform_utils_ccip_tx_af_buf_pkg.sv | 15 +
 rtl/platform_utils_af_fifo.sv | 73 +++++++
 rtl/platform_utils_ccip_tx_af_buf.sv | 87 ++++++++
 3 files changed

// File: rtl/platform_utils_ccip_tx_af_buf_pkg.sv
// Shared helpers for the CCI-P TX almost-full buffer: threshold arithmetic and
// elaboration-time parameter checking.
package platform_utils_ccip_tx_af_buf_pkg;

    // Slots that must stay free once almost full is raised: the AFU's send
    // allowance, the almost-full register stages, and the raw-flag cycle.
    function automatic int calc_thresh(input int afu_send_limit, input int n_af_reg_stages);
        return afu_send_limit + n_af_reg_stages + 1;
    endfunction

    function automatic bit params_ok(input int depth, input int thresh);
        return (depth > 0) && ((depth & (depth - 1)) == 0) && (depth >= 2 * thresh);
    endfunction

endpackage

// File: rtl/platform_utils_af_fifo.sv
// Single-channel FIFO with occupancy count, raw almost-full flag and a sticky
// overflow flag for writes that arrive while full.
module platform_utils_af_fifo
    import platform_utils_ccip_tx_af_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 600,
    parameter int DEPTH      = 64,
    parameter int THRESH     = 10,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_W-1:0]      occupancy_o,
    output logic                  raw_alm_full_o,
    output logic                  overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic                  ovf_q, ovf_d;
    logic                  full, empty, wr_en, rd_en;

    assign full  = (occ_q == CNT_W'(DEPTH));
    assign empty = (occ_q == '0);
    // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign wr_en = push_i & ~full;
    assign rd_en = pop_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q | (push_i & full);
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o         = mem_q[rd_ptr_q];
    assign occupancy_o    = occ_q;
    assign raw_alm_full_o = (occ_q >= CNT_W'(DEPTH - THRESH));
    assign overflow_o     = ovf_q;

endmodule

// File: rtl/platform_utils_ccip_tx_af_buf.sv
// Per-channel TX buffer between AFU and FIU that converts the FIU's almost-full
// into an early almost-full with enough slack for the AFU's in-flight sends.
module platform_utils_ccip_tx_af_buf
    import platform_utils_ccip_tx_af_buf_pkg::*;
#(
    parameter int N_CHANNELS      = 3,
    parameter int DATA_WIDTH      = 600,
    parameter int DEPTH           = 64,
    parameter int AFU_SEND_LIMIT  = 8,
    parameter int N_AF_REG_STAGES = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_CHANNELS-1:0]            afu_tx_valid,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] afu_tx_data,
    output logic [N_CHANNELS-1:0]            afu_tx_almFull,
    output logic [N_CHANNELS-1:0]            fiu_tx_valid,
    output logic [N_CHANNELS*DATA_WIDTH-1:0] fiu_tx_data,
    input  logic [N_CHANNELS-1:0]            fiu_tx_almFull,
    output logic [N_CHANNELS-1:0]            overflow_error
);
    localparam int THRESH = calc_thresh(AFU_SEND_LIMIT, N_AF_REG_STAGES);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    if (!params_ok(DEPTH, THRESH)) begin : g_param_err
        $error("DEPTH must be a power of two and at least 2*THRESH");
    end

    logic [N_CHANNELS-1:0] raw_af;

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        logic                  pop;
        logic [DATA_WIDTH-1:0] rd_data;
        logic [CNT_W-1:0]      occ;
        logic                  vld_q;
        logic [DATA_WIDTH-1:0] data_q;

        assign pop = (occ != '0) & ~fiu_tx_almFull[c];

        platform_utils_af_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .THRESH     (THRESH)
        ) u_fifo (
            .clk            (clk),
            .reset          (reset),
            .push_i         (afu_tx_valid[c]),
            .data_i         (afu_tx_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .pop_i          (pop),
            .data_o         (rd_data),
            .occupancy_o    (occ),
            .raw_alm_full_o (raw_af[c]),
            .overflow_o     (overflow_error[c])
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) vld_q <= 1'b0;
            else       vld_q <= pop;
        end

        // Payload is don't-care while valid is low, so it carries no reset.
        always_ff @(posedge clk) begin
            if (pop) data_q <= rd_data;
        end

        assign fiu_tx_valid[c]                          = vld_q;
        assign fiu_tx_data[c*DATA_WIDTH +: DATA_WIDTH] = data_q;
    end

    if (N_AF_REG_STAGES == 0) begin : g_af_direct
        assign afu_tx_almFull = raw_af | {N_CHANNELS{reset}};
    end else begin : g_af_pipe
        logic [N_AF_REG_STAGES-1:0][N_CHANNELS-1:0] af_pipe_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                af_pipe_q <= '1;
            end else begin
                af_pipe_q[0] <= raw_af;
                for (int s = 1; s < N_AF_REG_STAGES; s++) af_pipe_q[s] <= af_pipe_q[s-1];
            end
        end

        assign afu_tx_almFull = af_pipe_q[N_AF_REG_STAGES-1];
    end

endmodule
